// File: rtl/mtimer_pkg.sv
// ============================================================================
// Module  : mtimer_pkg
// Brief   : Register map, CTRL field positions and reset constants for mtimer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mtimer_pkg;

    localparam logic [4:0] MTIMER_OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] MTIMER_OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] MTIMER_OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] MTIMER_OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] MTIMER_OFF_CTRL        = 5'h10;

    localparam int unsigned MTIMER_CTRL_EN_BIT       = 0;
    localparam int unsigned MTIMER_CTRL_PRESCALE_LSB = 16;

    localparam logic [63:0] MTIMER_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] MTIMER_CTRL_RST     = 32'h0000_0001;

    localparam logic [1:0] MTIMER_WIDTH_WORD = 2'd2;

endpackage : mtimer_pkg

`default_nettype wire

// File: rtl/mtimer_if.sv
// ============================================================================
// Module  : mtimer_if
// Brief   : Core data-bus port seen by the machine timer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mtimer_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [1:0]  mem_width;
    logic [31:0] mem_rdata;
    logic        mem_sel;
    logic        bus_err;

    modport master (
        output mem_addr, mem_wdata, mem_read_en, mem_write_en, mem_width,
        input  mem_rdata, mem_sel, bus_err
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_read_en, mem_write_en, mem_width,
        output mem_rdata, mem_sel, bus_err
    );
endinterface : mtimer_if

`default_nettype wire

// File: rtl/mtimer_prescaler.sv
// ============================================================================
// Module  : mtimer_prescaler
// Brief   : Programmable divider producing one tick every PRESCALE+1 enabled cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mtimer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  en,
    input  wire logic                  clear,
    input  wire logic [PRESCALE_W-1:0] prescale,
    output logic                       tick
);

    logic [PRESCALE_W-1:0] r_pcnt;
    logic                  w_expire;

    assign w_expire = (r_pcnt == prescale);
    assign tick     = en & w_expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt <= '0;
        end else if (clear) begin
            r_pcnt <= '0;
        end else if (en) begin
            r_pcnt <= w_expire ? '0 : r_pcnt + 1'b1;
        end
    end

endmodule : mtimer_prescaler

`default_nettype wire

// File: rtl/mtimer.sv
// ============================================================================
// Module  : mtimer
// Brief   : Memory-mapped RISC-V machine timer (mtime/mtimecmp/CTRL) with
//           level timer interrupt. Prescaler built only with MTIMER_PRESCALE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mtimer
    import mtimer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int          PRESCALE_W = 16
) (
    input  wire logic  clk,
    input  wire logic  reset,
    mtimer_if.slave    bus,
    output logic       timer_irq
);

    logic [63:0]           r_mtime;
    logic [63:0]           r_mtimecmp;
    logic                  r_en;
    logic                  r_irq;
    logic                  r_bus_err;

    logic                  w_sel;
    logic                  w_legal;
    logic                  w_strobe;
    logic                  w_wr;
    logic [4:0]            w_offset;
    logic                  w_wr_mtime_lo;
    logic                  w_wr_mtime_hi;
    logic                  w_wr_cmp_lo;
    logic                  w_wr_cmp_hi;
    logic                  w_wr_ctrl;
    logic                  w_tick;
    logic [PRESCALE_W-1:0] w_prescale;
    logic [63:0]           w_mtime_inc;
    logic [63:0]           w_mtime_nxt;
    logic [63:0]           w_mtimecmp_nxt;
    logic [31:0]           w_ctrl_rd;
    logic [31:0]           w_rdata;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_sel    = (bus.mem_addr[31:5] == BASE_ADDR[31:5]);
    assign w_legal  = (bus.mem_width == MTIMER_WIDTH_WORD) && (bus.mem_addr[1:0] == 2'b00);
    assign w_strobe = bus.mem_read_en | bus.mem_write_en;
    assign w_wr     = w_sel & w_legal & bus.mem_write_en;
    assign w_offset = bus.mem_addr[4:0];

    assign w_wr_mtime_lo = w_wr && (w_offset == MTIMER_OFF_MTIME_LO);
    assign w_wr_mtime_hi = w_wr && (w_offset == MTIMER_OFF_MTIME_HI);
    assign w_wr_cmp_lo   = w_wr && (w_offset == MTIMER_OFF_MTIMECMP_LO);
    assign w_wr_cmp_hi   = w_wr && (w_offset == MTIMER_OFF_MTIMECMP_HI);
    assign w_wr_ctrl     = w_wr && (w_offset == MTIMER_OFF_CTRL);

    // ------------------------------------------------------------------
    // Tick source
    // ------------------------------------------------------------------
`ifdef MTIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] r_prescale;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescale <= MTIMER_CTRL_RST[MTIMER_CTRL_PRESCALE_LSB +: PRESCALE_W];
        end else if (w_wr_ctrl) begin
            r_prescale <= bus.mem_wdata[MTIMER_CTRL_PRESCALE_LSB +: PRESCALE_W];
        end
    end

    assign w_prescale = r_prescale;

    mtimer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (r_en),
        .clear    (w_wr_ctrl),
        .prescale (r_prescale),
        .tick     (w_tick)
    );
`else
    assign w_prescale = '0;
    assign w_tick     = r_en;
`endif

    // ------------------------------------------------------------------
    // Next-state for the 64-bit registers: a written half overrides its
    // own increment, the other half keeps counting (carry included).
    // ------------------------------------------------------------------
    assign w_mtime_inc = w_tick ? (r_mtime + 64'd1) : r_mtime;

    always_comb begin
        w_mtime_nxt    = w_mtime_inc;
        w_mtimecmp_nxt = r_mtimecmp;
        if (w_wr_mtime_lo) w_mtime_nxt[31:0]     = bus.mem_wdata;
        if (w_wr_mtime_hi) w_mtime_nxt[63:32]    = bus.mem_wdata;
        if (w_wr_cmp_lo)   w_mtimecmp_nxt[31:0]  = bus.mem_wdata;
        if (w_wr_cmp_hi)   w_mtimecmp_nxt[63:32] = bus.mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime    <= '0;
            r_mtimecmp <= MTIMER_MTIMECMP_RST;
            r_en       <= MTIMER_CTRL_RST[MTIMER_CTRL_EN_BIT];
            r_irq      <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_mtimecmp_nxt;
            if (w_wr_ctrl) begin
                r_en <= bus.mem_wdata[MTIMER_CTRL_EN_BIT];
            end
            r_irq      <= r_en & (r_mtime >= r_mtimecmp);
            r_bus_err  <= w_sel & w_strobe & ~w_legal;
        end
    end

    // ------------------------------------------------------------------
    // Zero-latency read mux: the core samples read data in the same cycle.
    // ------------------------------------------------------------------
    assign w_ctrl_rd = (32'(r_en) << MTIMER_CTRL_EN_BIT)
                     | (32'(w_prescale) << MTIMER_CTRL_PRESCALE_LSB);

    always_comb begin
        w_rdata = '0;
        if (w_sel && w_legal) begin
            case (w_offset)
                MTIMER_OFF_MTIME_LO:    w_rdata = r_mtime[31:0];
                MTIMER_OFF_MTIME_HI:    w_rdata = r_mtime[63:32];
                MTIMER_OFF_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
                MTIMER_OFF_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
                MTIMER_OFF_CTRL:        w_rdata = w_ctrl_rd;
                default:                w_rdata = '0;
            endcase
        end
    end

    assign bus.mem_rdata = w_rdata;
    assign bus.mem_sel   = w_sel;
    assign bus.bus_err   = r_bus_err;
    assign timer_irq     = r_irq;

endmodule : mtimer

`default_nettype wire
